// File: rtl/apc_mult_seq.sv
// Digit-serial multiplier controller: walks x one nibble per cycle through the
// external APC LUT and accumulates shifted partial products, stopping early on leading zeros.
module apc_mult_seq #(
    parameter int X_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [4:0]       i_a,
    input  logic [X_W-1:0]   i_x,
    output logic [3:0]       o_lut_x_dash,
    output logic [4:0]       o_lut_a,
    input  logic [8:0]       i_lut_prod,
    output logic             o_busy,
    output logic             o_done,
    output logic [X_W+4:0]   o_product
);
    // state  | meaning
    // S_IDLE | waiting for start, operands not yet captured
    // S_RUN  | one multiplier digit consumed per cycle
    // S_DONE | product valid, done pulsed for this single cycle

    localparam int N     = X_W / 4;
    localparam int PW    = X_W + 5;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [4:0]         r_a;
    logic [X_W-1:0]     r_x;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_product;
    logic               r_busy;
    logic               r_done;

    logic [3:0]         w_digit;
    logic [8:0]         w_partial;
    logic [PW-1:0]      w_partial_shifted;
    logic [PW-1:0]      w_acc_next;
    logic [X_W-1:0]     w_x_shifted;
    logic               w_last;

    assign w_digit = r_x[3:0];

    // The LUT answers 16*a for a zero digit, so that case must be masked here.
    assign w_partial         = (w_digit == 4'd0) ? 9'd0 : i_lut_prod;
    assign w_partial_shifted = PW'(w_partial) << {r_cnt, 2'b00};
    assign w_acc_next        = r_acc + w_partial_shifted;
    assign w_x_shifted       = r_x >> 4;
    assign w_last            = (r_cnt == CNT_W'(N - 1)) || (w_x_shifted == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_x       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_x     <= i_x;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_x   <= w_x_shifted;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The digit must reach the LUT within the RUN cycle, so it is decoded from state, not staged.
    assign o_lut_x_dash = (r_state == S_RUN) ? w_digit : 4'd0;
    assign o_lut_a      = r_a;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_product    = r_product;

endmodule

// File: tb/tb_apc_mult_seq.sv
// Self-checking bench for apc_mult_seq with a behavioural APC LUT attached;
// expected products come from plain a*x and latency from the highest nonzero digit.
module tb_apc_mult_seq;
    localparam int X_W = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [4:0]    i_a;
    logic [15:0]   i_x;
    logic [3:0]    o_lut_x_dash;
    logic [4:0]    o_lut_a;
    logic [8:0]    w_lut_prod;
    logic          o_busy;
    logic          o_done;
    logic [20:0]   o_product;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    // APC LUT: exact digit*a, except digit 0 returns 16*a.
    assign w_lut_prod = (o_lut_x_dash == 4'd0) ? {o_lut_a, 4'b0000}
                                               : 9'(o_lut_x_dash) * 9'(o_lut_a);

    apc_mult_seq #(.X_W(X_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_a          (i_a),
        .i_x          (i_x),
        .o_lut_x_dash (o_lut_x_dash),
        .o_lut_a      (o_lut_a),
        .i_lut_prod   (w_lut_prod),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_product    (o_product)
    );

    typedef struct {
        logic [4:0]  a;
        logic [15:0] x;
        logic [20:0] exp_p;
        int          exp_k;
    } vec_t;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int k_of(input logic [15:0] x);
        for (int i = 3; i >= 0; i--)
            if (((x >> (4 * i)) & 16'hF) != 0) return i + 1;
        return 1;
    endfunction

    // One complete operation from IDLE, checking every cycle up to the return to IDLE.
    task automatic run_op(input string nm, input logic [4:0] a, input logic [15:0] x,
                          input logic [20:0] exp_p, input int exp_k);
        int cyc;
        i_a = a; i_x = x; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_a = 5'($urandom);
        i_x = 16'($urandom);
        cyc = 1;
        while (!o_done && cyc <= 20) begin
            if (cyc <= exp_k) begin
                chk({nm, " lut_x_dash"}, o_lut_x_dash, (x >> (4 * (cyc - 1))) & 16'hF);
                chk({nm, " busy_run"}, o_busy, 1);
                chk({nm, " lut_a"}, o_lut_a, a);
            end
            tick();
            cyc++;
        end
        if (!o_done) begin
            chk({nm, " done_timeout"}, 0, 1);
        end else begin
            chk({nm, " latency"}, cyc, exp_k + 1);
            chk({nm, " product"}, o_product, exp_p);
            chk({nm, " busy_done"}, o_busy, 1);
            chk({nm, " lut_x_dash_done"}, o_lut_x_dash, 0);
        end
        tick();
        chk({nm, " idle_busy"}, o_busy, 0);
        chk({nm, " idle_done"}, o_done, 0);
        chk({nm, " product_hold"}, o_product, exp_p);
    endtask

    initial begin
        vec_t vecs[6];
        int   c, done1, done2;
        logic [20:0] p1, p2;
        logic [4:0]  ra;
        logic [15:0] rx;

        vecs[0] = '{a: 5'd31, x: 16'hFFFF, exp_p: 21'd2031585, exp_k: 4};
        vecs[1] = '{a: 5'd5,  x: 16'h0003, exp_p: 21'd15,      exp_k: 1};
        vecs[2] = '{a: 5'd7,  x: 16'h1000, exp_p: 21'd28672,   exp_k: 4};
        vecs[3] = '{a: 5'd31, x: 16'h0000, exp_p: 21'd0,       exp_k: 1};
        vecs[4] = '{a: 5'd0,  x: 16'h00FF, exp_p: 21'd0,       exp_k: 2};
        vecs[5] = '{a: 5'd9,  x: 16'h0A0B, exp_p: 21'd23139,   exp_k: 3};

        i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_x = '0;
        tick(); tick();
        chk("rst busy", o_busy, 0);
        chk("rst done", o_done, 0);
        chk("rst product", o_product, 0);
        chk("rst lut_x_dash", o_lut_x_dash, 0);
        chk("rst lut_a", o_lut_a, 0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].x, vecs[i].exp_p, vecs[i].exp_k);

        // Start held high: second request only accepted once back in IDLE.
        i_a = 5'd3; i_x = 16'h0102; i_start = 1'b1;
        done1 = -1; done2 = -1; p1 = '0; p2 = '0;
        c = 0;
        while (c < 12) begin
            tick();
            c++;
            if (c == 2) i_x = 16'h0005;
            if (o_done && done1 < 0) begin done1 = c; p1 = o_product; end
            else if (o_done && done2 < 0) begin done2 = c; p2 = o_product; i_start = 1'b0; end
        end
        i_start = 1'b0;
        chk("held done1 cycle", done1, 4);
        chk("held product1", p1, 774);
        chk("held done2 cycle", done2, 7);
        chk("held product2", p2, 15);
        tick(); tick();

        // Reset in cycle 2 of a long operation.
        i_a = 5'd31; i_x = 16'hFFFF; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst busy", o_busy, 0);
        chk("midrst done", o_done, 0);
        chk("midrst product", o_product, 0);
        chk("midrst lut_x_dash", o_lut_x_dash, 0);
        done1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_done || o_busy) done1++;
            tick();
        end
        chk("midrst no done", done1, 0);
        run_op("post_rst", 5'd2, 16'h0010, 21'd32, 2);

        // Randomized operands with a random number of significant digits.
        for (int i = 0; i < 40; i++) begin
            ra = 5'($urandom);
            rx = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            run_op($sformatf("rnd%0d", i), ra, rx, 21'(ra) * 21'(rx), k_of(rx));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
